// File: rtl/nibble_serial_adder_ctrl.sv
// Nibble-serial WIDTH-bit adder sequencer around a single 4-bit ripple slice.
// Optional subtract mode is enabled by defining NIBBLE_SERIAL_SUB_EN.

module bit4_full_adder (
   input  logic [3:0] a_i,
   input  logic [3:0] b_i,
   input  logic       cin_i,
   output logic [3:0] sum_o,
   output logic       cout_o
);
   logic [4:0] cy;

   always_comb begin
      cy    = '0;
      sum_o = '0;
      cy[0] = cin_i;
      for (int i = 0; i < 4; i++) begin
         sum_o[i]  = a_i[i] ^ b_i[i] ^ cy[i];
         cy[i + 1] = (a_i[i] & b_i[i]) | (cy[i] & (a_i[i] ^ b_i[i]));
      end
      cout_o = cy[4];
   end
endmodule

module nibble_serial_adder_ctrl #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
`ifdef NIBBLE_SERIAL_SUB_EN
   input  logic             sub,
`endif
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             c_out
);
   localparam int NIB   = WIDTH / 4;
   localparam int CNT_W = (NIB > 1) ? $clog2(NIB) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(NIB - 1);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_sh_q, a_sh_d;
   logic [WIDTH-1:0] b_sh_q, b_sh_d;
   logic             carry_q, carry_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic             c_out_q, c_out_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;

   logic [3:0]       slice_sum;
   logic             slice_cout;
   logic [WIDTH-1:0] slice_ext;
   logic [WIDTH-1:0] b_lat;
   logic             cin_lat;

   // Subtraction reuses the adder: a + ~b + 1.
`ifdef NIBBLE_SERIAL_SUB_EN
   assign b_lat   = sub ? ~b : b;
   assign cin_lat = sub ? 1'b1 : cin;
`else
   assign b_lat   = b;
   assign cin_lat = cin;
`endif

   bit4_full_adder u_slice (
      .a_i    (a_sh_q[3:0]),
      .b_i    (b_sh_q[3:0]),
      .cin_i  (carry_q),
      .sum_o  (slice_sum),
      .cout_o (slice_cout)
   );

   assign slice_ext = WIDTH'(slice_sum);

   always_comb begin
      state_d = state_q;
      a_sh_d  = a_sh_q;
      b_sh_d  = b_sh_q;
      carry_d = carry_q;
      cnt_d   = cnt_q;
      sum_d   = sum_q;
      c_out_d = c_out_q;
      case (state_q)
         S_IDLE, S_DONE: begin
            state_d = S_IDLE;
            if (start) begin
               a_sh_d  = a;
               b_sh_d  = b_lat;
               carry_d = cin_lat;
               cnt_d   = '0;
               state_d = S_RUN;
            end
         end
         S_RUN: begin
            // Each slice result enters at the top; after NIB shifts nibble 0 sits at [3:0].
            sum_d   = (sum_q >> 4) | (slice_ext << (WIDTH - 4));
            a_sh_d  = a_sh_q >> 4;
            b_sh_d  = b_sh_q >> 4;
            carry_d = slice_cout;
            cnt_d   = cnt_q + CNT_W'(1);
            if (cnt_q == LAST) begin
               c_out_d = slice_cout;
               state_d = S_DONE;
            end
         end
         default: state_d = S_IDLE;
      endcase
      busy_d = (state_d == S_RUN);
      done_d = (state_d == S_DONE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         a_sh_q  <= '0;
         b_sh_q  <= '0;
         carry_q <= 1'b0;
         cnt_q   <= '0;
         sum_q   <= '0;
         c_out_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         a_sh_q  <= a_sh_d;
         b_sh_q  <= b_sh_d;
         carry_q <= carry_d;
         cnt_q   <= cnt_d;
         sum_q   <= sum_d;
         c_out_q <= c_out_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign busy  = busy_q;
   assign done  = done_q;
   assign sum   = sum_q;
   assign c_out = c_out_q;
endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// Scoreboard bench for nibble_serial_adder_ctrl (WIDTH=16); covers the
// subtract path when NIBBLE_SERIAL_SUB_EN is defined.

module tb_nibble_serial_adder_ctrl;
   localparam int W   = 16;
   localparam int NIB = W / 4;

   typedef struct {
      logic [W-1:0] s;
      logic         c;
      int           acc;
   } exp_t;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         start = 1'b0;
   logic [W-1:0] a = '0;
   logic [W-1:0] b = '0;
   logic         cin = 1'b0;
`ifdef NIBBLE_SERIAL_SUB_EN
   logic         sub_r = 1'b0;
`endif
   logic         busy, done, c_out;
   logic [W-1:0] sum;

   exp_t sb[$];
   int   vectors = 0;
   int   miscompares = 0;
   int   edge_cnt = 0;
   int   busy_cnt = 0;

   nibble_serial_adder_ctrl #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .a     (a),
      .b     (b),
      .cin   (cin),
`ifdef NIBBLE_SERIAL_SUB_EN
      .sub   (sub_r),
`endif
      .busy  (busy),
      .done  (done),
      .sum   (sum),
      .c_out (c_out)
   );

   always #5 clk = ~clk;
   always @(posedge clk) edge_cnt <= edge_cnt + 1;
   always @(posedge rst) busy_cnt = 0;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   // Monitor: compares every done pulse against the head of the scoreboard.
   always @(negedge clk) begin
      if (!rst) begin
         if (busy) busy_cnt++;
         if (done) begin
            if (sb.size() == 0) begin
               vectors++;
               miscompares++;
               $display("FAIL unexpected_done: got done=1 expected no done (sum=0x%0h)", sum);
            end else begin
               exp_t e;
               e = sb.pop_front();
               check("sum", 32'(sum), 32'(e.s));
               check("c_out", 32'(c_out), 32'(e.c));
               check("latency", 32'(edge_cnt + 1 - e.acc), 32'(NIB + 1));
               check("busy_cycles", 32'(busy_cnt), 32'(NIB));
            end
            busy_cnt = 0;
         end
      end
   end

   // Caller positions time away from the rising edge; start is sampled at the next one.
   task automatic do_start(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tc,
                           input bit push, input logic [W-1:0] es, input logic ec);
      exp_t e;
      a = ta; b = tb_v; cin = tc; start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      if (push) begin
         e.s = es; e.c = ec; e.acc = edge_cnt;
         sb.push_back(e);
      end
   endtask

   task automatic wait_idle();
      int n = 0;
      while ((sb.size() != 0 || busy || done) && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (n >= 100) begin
         vectors++;
         miscompares++;
         $display("FAIL wait_idle_timeout: got busy=%0b pending=%0d expected idle", busy, sb.size());
      end
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1);
   end

   initial begin
      #1;
      check("rst_busy", 32'(busy), 32'h0);
      check("rst_done", 32'(done), 32'h0);
      check("rst_sum", 32'(sum), 32'h0);
      check("rst_c_out", 32'(c_out), 32'h0);
      repeat (2) @(negedge clk);
      rst = 1'b0;

      // Basic add and ripple cases
      @(negedge clk); do_start(16'h1234, 16'h4321, 1'b0, 1, 16'h5555, 1'b0); wait_idle();
      @(negedge clk); do_start(16'hFFFF, 16'h0001, 1'b0, 1, 16'h0000, 1'b1); wait_idle();
      @(negedge clk); do_start(16'h0000, 16'h0000, 1'b1, 1, 16'h0001, 1'b0); wait_idle();
      @(negedge clk); do_start(16'hA5A5, 16'h5A5A, 1'b1, 1, 16'h0000, 1'b1); wait_idle();
      @(negedge clk); do_start(16'h7FFF, 16'h7FFF, 1'b1, 1, 16'hFFFF, 1'b0); wait_idle();

      // Start while busy is ignored; result holds afterwards
      @(negedge clk); do_start(16'h00FF, 16'h0001, 1'b0, 1, 16'h0100, 1'b0);
      @(posedge clk);
      @(negedge clk); do_start(16'hAAAA, 16'h5555, 1'b0, 0, 16'h0000, 1'b0);
      wait_idle();
      repeat (2) @(negedge clk);
      check("hold_sum", 32'(sum), 32'h0100);
      check("hold_c_out", 32'(c_out), 32'h0);

      // Back-to-back: start asserted in the DONE cycle
      @(negedge clk); do_start(16'h0F0F, 16'h0101, 1'b0, 1, 16'h1010, 1'b0);
      begin
         int n = 0;
         while (!done && n < 20) begin @(negedge clk); n++; end
         check("b2b_done_seen", 32'(done), 32'h1);
      end
      do_start(16'h8000, 16'h8000, 1'b0, 1, 16'h0000, 1'b1);
      check("b2b_busy", 32'(busy), 32'h1);
      wait_idle();

      // Asynchronous reset during the second RUN cycle
      @(negedge clk); do_start(16'h1111, 16'h2222, 1'b0, 0, 16'h0000, 1'b0);
      @(posedge clk);
      #2 rst = 1'b1;
      #1;
      check("abort_busy", 32'(busy), 32'h0);
      check("abort_done", 32'(done), 32'h0);
      check("abort_sum", 32'(sum), 32'h0);
      check("abort_c_out", 32'(c_out), 32'h0);
      #1 rst = 1'b0;
      repeat (8) @(negedge clk);
      do_start(16'h1111, 16'h2222, 1'b0, 1, 16'h3333, 1'b0); wait_idle();

`ifdef NIBBLE_SERIAL_SUB_EN
      @(negedge clk); sub_r = 1'b1;
      do_start(16'h0005, 16'h0007, 1'b0, 1, 16'hFFFE, 1'b0); wait_idle();
      @(negedge clk);
      do_start(16'h0007, 16'h0005, 1'b0, 1, 16'h0002, 1'b1); wait_idle();
      @(negedge clk); sub_r = 1'b0;
      do_start(16'h0007, 16'h0005, 1'b0, 1, 16'h000C, 1'b0); wait_idle();
`endif

      repeat (3) @(negedge clk);
      check("sb_empty", 32'(sb.size()), 32'h0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
